// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath width, the supported opcode set and the fetch FSM states.
// Imported by the fetch unit and by the main decoder.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // Instruction addresses are always word aligned; low bits are simply dropped.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with redirect handling: holds pc, the saved redirect target and the
// kill flag that discards an in-flight read, and selects the next pc.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  fetch_state_t      state,
  input  logic              imem_ack,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_target,
  output logic [WORD_W-1:0] pc,
  output logic              kill,
  output logic              misalign_err
);

  logic [WORD_W-1:0] saved_target;
  logic              hold_redir;
  logic [WORD_W-1:0] target_aligned;
  logic [WORD_W-1:0] pc_inc;
  logic              redirect_taken;

  assign target_aligned = align_word(redirect_target);
  assign pc_inc         = pc + 32'd4;
  assign redirect_taken = redirect && (state != BOOT);

  // NOTE: every register here uses <= so all next-state terms see the pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc           <= RESET_PC;
      saved_target <= '0;
      kill         <= 1'b0;
      hold_redir   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (redirect_taken && (redirect_target[1:0] != 2'b00))
        misalign_err <= 1'b1;

      case (state)
        FETCH: begin
          if (imem_ack) begin
            // A redirect coinciding with the ack kills that data just like a pending kill.
            if (redirect) begin
              pc   <= target_aligned;
              kill <= 1'b0;
            end else if (kill) begin
              pc   <= saved_target;
              kill <= 1'b0;
            end
          end else if (redirect) begin
            saved_target <= target_aligned;
            kill         <= 1'b1;
          end
        end

        HOLD: begin
          if (instr_ready) begin
            if (redirect)        pc <= target_aligned;
            else if (hold_redir) pc <= saved_target;
            else                 pc <= pc_inc;
            hold_redir <= 1'b0;
          end else if (redirect) begin
            saved_target <= target_aligned;
            hold_redir   <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle MIPS instruction fetch stage: req/ack reads from instruction memory into an
// instruction register presented to the decoder over valid/ready.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              illegal_op,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_target,
  output logic              misalign_err,
  output logic [WORD_W-1:0] fetch_count
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic              kill;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .reset_n         (reset_n),
    .state           (state),
    .imem_ack        (imem_ack),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc              (pc),
    .kill            (kill),
    .misalign_err    (misalign_err)
  );

  // Handshake outputs decode straight from the state register; the address follows pc.
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign opcode      = instr[31:26];
  assign illegal_op  = instr_valid && !op_supported(opcode);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= BOOT;
      instr       <= '0;
      pc_plus4    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: state <= FETCH;

        FETCH: begin
          // Killed data is dropped; the pc register moves to the redirect target instead.
          if (imem_ack && !kill && !redirect) begin
            instr    <= imem_rdata;
            pc_plus4 <= pc + 32'd4;
            state    <= HOLD;
          end
        end

        HOLD: begin
          if (instr_ready) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= FETCH;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a randomized
// run against a transaction-level reference model of the fetch stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        illegal_op;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .opcode          (opcode),
    .pc_plus4        (pc_plus4),
    .illegal_op      (illegal_op),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  // Reference memory contents: a hashed word whose opcode field mixes legal and illegal codes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [5:0]  op;
    h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    case (h[29:27])
      3'd0: op = 6'b000000;
      3'd1: op = 6'b100011;
      3'd2: op = 6'b101011;
      3'd3: op = 6'b000100;
      3'd4: op = 6'b001000;
      3'd5: op = 6'b000010;
      3'd6: op = 6'b111111;
      default: op = 6'b010101;
    endcase
    return {op, h[25:0]};
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
  endfunction

  task automatic idle_inputs();
    imem_ack        = 1'b0;
    imem_rdata      = 32'h0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
  endtask

  // Holds reset for two edges, releases it and returns at the first FETCH cycle.
  task automatic apply_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // From a FETCH cycle: `waits` stall cycles, then ack with `word`; returns in HOLD.
  task automatic fetch_ack(input int waits, input logic [31:0] word);
    imem_ack = 1'b0;
    repeat (waits) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  // From HOLD: accept the instruction, optionally with a redirect; returns in FETCH.
  task automatic accept(input logic redir, input logic [31:0] tgt);
    instr_ready     = 1'b1;
    redirect        = redir;
    redirect_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0;
    redirect    = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    logic [31:0] got  [10];
    logic [31:0] want [10];
    string       nm   [10];
    got[0] = {31'b0, imem_req};     want[0] = 32'h0;     nm[0] = "imem_req";
    got[1] = imem_addr;             want[1] = RESET_PC;  nm[1] = "imem_addr";
    got[2] = {31'b0, instr_valid};  want[2] = 32'h0;     nm[2] = "instr_valid";
    got[3] = instr;                 want[3] = 32'h0;     nm[3] = "instr";
    got[4] = {26'b0, opcode};       want[4] = 32'h0;     nm[4] = "opcode";
    got[5] = pc_plus4;              want[5] = 32'h0;     nm[5] = "pc_plus4";
    got[6] = {31'b0, illegal_op};   want[6] = 32'h0;     nm[6] = "illegal_op";
    got[7] = {31'b0, misalign_err}; want[7] = 32'h0;     nm[7] = "misalign_err";
    got[8] = fetch_count;           want[8] = 32'h0;     nm[8] = "fetch_count";
    got[9] = {31'b0, imem_req};     want[9] = 32'h0;     nm[9] = "imem_req_again";
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== want[i])
        $display("FAIL %s %s: got %h expected %h", tag, nm[i], got[i], want[i]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    idle_inputs();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    imem_ack = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL boot_to_fetch: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    else passed++;
  endtask

  task automatic test_zero_wait();
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C08_0004;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h8C08_0004 || pc_plus4 !== 32'h4)
      $display("FAIL zw_hold: valid=%b instr=%h pc4=%h expected 1 8c080004 4", instr_valid, instr, pc_plus4);
    else passed++;
    checks++;
    if (opcode !== 6'b100011 || illegal_op !== 1'b0)
      $display("FAIL zw_opcode: opcode=%b illegal=%b expected 100011 0", opcode, illegal_op);
    else passed++;
    accept(1'b0, 32'h0);
    checks++;
    if (fetch_count !== 32'd1 || imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL zw_second: count=%0d req=%b addr=%h expected 1 1 4", fetch_count, imem_req, imem_addr);
    else passed++;
    fetch_ack(0, 32'h0000_0020);
    accept(1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h8)
      $display("FAIL zw_third_addr: got %h expected 00000008", imem_addr);
    else passed++;
  endtask

  task automatic test_wait_hold();
    logic [31:0] word;
    int lat;
    word = 32'hAC09_0010;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8)
        $display("FAIL wait_addr_stable cycle %0d: req=%b addr=%h expected 1 00000008", i, imem_req, imem_addr);
      else passed++;
      imem_ack   = (i == 3);
      imem_rdata = (i == 3) ? word : 32'h1111_1111;
      @(negedge clk);
    end
    imem_ack    = 1'b0;
    lat         = 0;
    instr_ready = 1'b0;
    while (instr_valid === 1'b1 && lat < 10) begin
      checks++;
      if (instr !== word)
        $display("FAIL hold_instr_stable cycle %0d: got %h expected %h", lat, instr, word);
      else passed++;
      instr_ready = (lat >= 2);
      lat++;
      @(negedge clk);
    end
    instr_ready = 1'b0;
    checks++;
    if (lat != 3)
      $display("FAIL valid_to_accept_latency: got %0d expected 3", lat);
    else passed++;
    checks++;
    if (fetch_count !== 32'd3 || imem_addr !== 32'hC)
      $display("FAIL after_wait: count=%0d addr=%h expected 3 0000000c", fetch_count, imem_addr);
    else passed++;
  endtask

  task automatic test_redirect_hold();
    fetch_ack(1, 32'h1000_0001);
    accept(1'b0, 32'h0);
    fetch_ack(0, 32'h2008_0005);
    checks++;
    if (instr_valid !== 1'b1 || pc_plus4 !== 32'h14)
      $display("FAIL rh_hold_at_10: valid=%b pc4=%h expected 1 00000014", instr_valid, pc_plus4);
    else passed++;
    accept(1'b1, 32'h40);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40)
      $display("FAIL rh_target: req=%b addr=%h expected 1 00000040", imem_req, imem_addr);
    else passed++;
  endtask

  task automatic test_redirect_fetch();
    fetch_ack(0, 32'h0800_0010);
    accept(1'b1, 32'h20);
    checks++;
    if (imem_addr !== 32'h20)
      $display("FAIL rf_start: addr=%h expected 00000020", imem_addr);
    else passed++;
    @(negedge clk);
    redirect        = 1'b1;
    redirect_target = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20)
      $display("FAIL rf_inflight_kept: req=%b addr=%h expected 1 00000020", imem_req, imem_addr);
    else passed++;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80)
      $display("FAIL rf_discard: valid=%b req=%b addr=%h expected 0 1 00000080", instr_valid, imem_req, imem_addr);
    else passed++;
    fetch_ack(0, 32'h0000_0825);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_0825 || pc_plus4 !== 32'h84)
      $display("FAIL rf_new_word: valid=%b instr=%h pc4=%h expected 1 00000825 00000084", instr_valid, instr, pc_plus4);
    else passed++;
  endtask

  task automatic test_misalign();
    checks++;
    if (misalign_err !== 1'b0)
      $display("FAIL misalign_initial: got %b expected 0", misalign_err);
    else passed++;
    accept(1'b1, 32'h43);
    checks++;
    if (imem_addr !== 32'h40 || misalign_err !== 1'b1)
      $display("FAIL misalign_set: addr=%h err=%b expected 00000040 1", imem_addr, misalign_err);
    else passed++;
    fetch_ack(2, 32'h0000_0000);
    accept(1'b0, 32'h0);
    checks++;
    if (misalign_err !== 1'b1 || imem_addr !== 32'h44)
      $display("FAIL misalign_sticky: err=%b addr=%h expected 1 00000044", misalign_err, imem_addr);
    else passed++;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0)
      $display("FAIL misalign_cleared: got %b expected 0", misalign_err);
    else passed++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    fetch_ack(0, 32'h0000_0000);
    accept(1'b1, 32'hFFFF_FFFC);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_target: addr=%h expected fffffffc", imem_addr);
    else passed++;
    fetch_ack(1, 32'h0800_0000);
    checks++;
    if (pc_plus4 !== 32'h0)
      $display("FAIL wrap_pc_plus4: got %h expected 00000000", pc_plus4);
    else passed++;
    accept(1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0)
      $display("FAIL wrap_next_addr: got %h expected 00000000", imem_addr);
    else passed++;
  endtask

  task automatic test_illegal_and_reset();
    fetch_ack(1, 32'hFC00_0000);
    checks++;
    if (instr_valid !== 1'b1 || opcode !== 6'b111111 || illegal_op !== 1'b1)
      $display("FAIL illegal_op: valid=%b opcode=%b illegal=%b expected 1 111111 1", instr_valid, opcode, illegal_op);
    else passed++;
    accept(1'b0, 32'h0);
    @(negedge clk);
    reset_n    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C08_0004;
    @(negedge clk);
    check_reset_values("mid_fetch_reset");
    imem_ack = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL post_reset_fetch: valid=%b req=%b addr=%h expected 0 1 %h", instr_valid, imem_req, imem_addr, RESET_PC);
    else passed++;
  endtask

  // Model: a redirect in any cycle names the address of the next instruction to become valid;
  // otherwise each delivered instruction follows its predecessor by 4.
  task automatic test_random(input int ncycles);
    logic [31:0] exp_addr, exp_word, held, prev_addr, tgt;
    logic [31:0] exp_count;
    logic        exp_mis, prev_valid, prev_req, prev_ack;
    int          waits_left;
    apply_reset();
    exp_addr   = RESET_PC;
    exp_count  = 32'd0;
    exp_mis    = 1'b0;
    prev_valid = 1'b0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = 32'h0;
    held       = 32'h0;
    waits_left = 0;
    for (int c = 0; c < ncycles; c++) begin
      checks++;
      if (fetch_count !== exp_count || misalign_err !== exp_mis)
        $display("FAIL rnd_counters cycle %0d: count=%0d err=%b expected %0d %b", c, fetch_count, misalign_err, exp_count, exp_mis);
      else passed++;

      if (instr_valid === 1'b1 && !prev_valid) begin
        exp_word = mem_word(exp_addr);
        checks++;
        if (instr !== exp_word || pc_plus4 !== exp_addr + 32'd4 ||
            opcode !== exp_word[31:26] || illegal_op !== !legal_op(exp_word[31:26]))
          $display("FAIL rnd_deliver cycle %0d: instr=%h pc4=%h op=%b ill=%b expected %h %h %b %b",
                   c, instr, pc_plus4, opcode, illegal_op, exp_word, exp_addr + 32'd4,
                   exp_word[31:26], !legal_op(exp_word[31:26]));
        else passed++;
        held     = exp_word;
        exp_addr = exp_addr + 32'd4;
      end else if (instr_valid === 1'b1 && prev_valid) begin
        checks++;
        if (instr !== held)
          $display("FAIL rnd_hold_stable cycle %0d: instr=%h expected %h", c, instr, held);
        else passed++;
      end

      if (imem_req === 1'b1 && prev_req && !prev_ack) begin
        checks++;
        if (imem_addr !== prev_addr)
          $display("FAIL rnd_addr_stable cycle %0d: addr=%h expected %h", c, imem_addr, prev_addr);
        else passed++;
      end

      if (imem_req === 1'b1) begin
        if (!prev_req || prev_ack) waits_left = $urandom_range(0, 3);
        imem_ack   = (waits_left == 0);
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
        waits_left--;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end

      instr_ready = instr_valid ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      if (instr_valid === 1'b1 && instr_ready) exp_count = exp_count + 32'd1;

      redirect = ($urandom_range(0, 9) == 0);
      tgt      = {$urandom_range(0, 255) << 2};
      if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      redirect_target = redirect ? tgt : $urandom;
      if (redirect) begin
        exp_addr = {tgt[31:2], 2'b00};
        if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
      end

      prev_valid = (instr_valid === 1'b1);
      prev_req   = (imem_req === 1'b1);
      prev_ack   = imem_ack;
      prev_addr  = imem_addr;
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (exp_count < 32'd100)
      $display("FAIL rnd_progress: accepted %0d instructions, expected at least 100", exp_count);
    else passed++;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_wait_hold();
    test_redirect_hold();
    test_redirect_fetch();
    test_misalign();
    test_wrap();
    test_illegal_and_reset();
    test_random(3000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
